// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: timed main/side/pedestrian light sequencer; define TRAFFIC_WALK_EN to enable the pedestrian WALK phase
module traffic_light_fsm #(
  parameter int MAX_T = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_Hz_Enable,
  input  logic       sensor,
  input  logic       walk_Request,
  input  logic       sync_Reprogram,
  input  logic [3:0] param_Value,
  output logic [1:0] interval,
  output logic [2:0] main_Lights,
  output logic [2:0] side_Lights,
  output logic       walk,
  output logic [3:0] time_Left
);
`ifdef TRAFFIC_WALK_EN
  localparam bit WALK_EN = 1'b1;
`else
  localparam bit WALK_EN = 1'b0;
`endif
  localparam logic [3:0] MAX_V = 4'(MAX_T);
  typedef enum logic [2:0] {MG, MG_EXT, MY, WALK, SG, SG_EXT, SY} state_t;
  state_t state, state_n, succ;
  logic [3:0] cnt, cnt_n, load_v;
  logic seen, seen_n, pend, pend_n, seen_eff, load, expire, illegal, restart;
  // state, countdown and sticky request flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MG;
      cnt   <= 4'd0;
      seen  <= 1'b0;
      pend  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      seen  <= seen_n;
      pend  <= pend_n;
    end
  end
  // counter zero marks the LOAD cycle; lamps and interval code decode from state
  always_comb begin
    load        = cnt == 4'd0;
    expire      = !load && one_Hz_Enable && cnt == 4'd1 && !sync_Reprogram;
    seen_eff    = seen | (sensor & (state == MG || state == MG_EXT));
    load_v      = param_Value == 4'd0 ? 4'd1 : (param_Value > MAX_V ? MAX_V : param_Value);
    succ        = MG;
    illegal     = 1'b0;
    interval    = 2'b00;
    main_Lights = 3'b001;
    side_Lights = 3'b100;
    case (state)
      MG:      succ = seen_eff ? MY : MG_EXT;
      MG_EXT:  begin succ = MY; interval = 2'b01; end
      MY:      begin succ = (WALK_EN && pend) ? WALK : SG; interval = 2'b10; main_Lights = 3'b010; end
      WALK:    begin succ = SG; interval = 2'b01; main_Lights = 3'b100; end
      SG:      begin succ = sensor ? SG_EXT : SY; main_Lights = 3'b100; side_Lights = 3'b001; end
      SG_EXT:  begin succ = SY; interval = 2'b01; main_Lights = 3'b100; side_Lights = 3'b001; end
      SY:      begin succ = MG; interval = 2'b10; main_Lights = 3'b100; side_Lights = 3'b010; end
      default: illegal = 1'b1;
    endcase
    restart   = sync_Reprogram || illegal;
    walk      = WALK_EN && state == WALK;
    time_Left = cnt;
    state_n   = restart ? MG : expire ? succ : state;
    cnt_n     = (restart || expire) ? 4'd0 : load ? load_v : one_Hz_Enable ? cnt - 4'd1 : cnt;
    seen_n    = (restart || (expire && succ == MG)) ? 1'b0 : seen_eff;
    pend_n    = WALK_EN && ((pend && !(expire && state == WALK)) || walk_Request);
  end
endmodule

// File: tb/tb_traffic_light_fsm.sv
// tb_traffic_light_fsm: vector table, corner sequences and random run against a phase-level reference model
module tb_traffic_light_fsm;
`ifdef TRAFFIC_WALK_EN
  localparam bit WEN = 1'b1;
`else
  localparam bit WEN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1, one_Hz_Enable = 1'b0, sensor = 1'b0, walk_Request = 1'b0, sync_Reprogram = 1'b0;
  logic [3:0] param_Value;
  logic [1:0] interval;
  logic [2:0] main_Lights, side_Lights;
  logic walk;
  logic [3:0] time_Left;
  logic [3:0] prog [4];
  int n_assert = 0, n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;
  assign param_Value = prog[interval];

  traffic_light_fsm dut (
    .clk(clk), .reset(reset), .one_Hz_Enable(one_Hz_Enable), .sensor(sensor),
    .walk_Request(walk_Request), .sync_Reprogram(sync_Reprogram), .param_Value(param_Value),
    .interval(interval), .main_Lights(main_Lights), .side_Lights(side_Lights),
    .walk(walk), .time_Left(time_Left)
  );

  // phases: 0 MG, 1 MG_EXT, 2 MY, 3 WALK, 4 SG, 5 SG_EXT, 6 SY
  typedef struct { int ph; int left; bit seen; bit pend; } mstate_t;
  mstate_t m = '{0, 0, 1'b0, 1'b0};
  int code_t [7] = '{0, 1, 2, 1, 0, 1, 2};
  int main_t [7] = '{1, 1, 2, 4, 4, 4, 4};
  int side_t [7] = '{4, 4, 4, 4, 1, 1, 2};

  function automatic int next_phase(int ph, bit seen_eff, bit pend, bit sns);
    case (ph)
      0: return seen_eff ? 2 : 1;
      1: return 2;
      2: return (WEN && pend) ? 3 : 4;
      3: return 4;
      4: return sns ? 5 : 6;
      5: return 6;
      default: return 0;
    endcase
  endfunction

  function automatic int duration(int v);
    return v == 0 ? 1 : (v > 15 ? 15 : v);
  endfunction

  function automatic mstate_t mstep(mstate_t c, bit tk, bit sn, bit wr, bit rp, bit rs);
    mstate_t n = c;
    bit seen_eff = c.seen | (sn & (c.ph <= 1));
    bit expire = !rp && tk && c.left == 1;
    if (rs) return '{0, 0, 1'b0, 1'b0};
    n.seen = seen_eff;
    n.pend = WEN && ((c.pend && !(expire && c.ph == 3)) || wr);
    if (rp) begin
      n.ph = 0; n.left = 0; n.seen = 1'b0;
    end else if (c.left == 0) n.left = duration(int'(prog[code_t[c.ph]]));
    else if (expire) begin
      n.ph = next_phase(c.ph, seen_eff, c.pend, sn);
      n.left = 0;
      if (n.ph == 0) n.seen = 1'b0;
    end else if (tk) n.left = c.left - 1;
    return n;
  endfunction

  always @(posedge clk) m <= mstep(m, one_Hz_Enable, sensor, walk_Request, sync_Reprogram, reset);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check("model_interval", 32'(interval), 32'(code_t[m.ph]));
    check("model_main", 32'(main_Lights), 32'(main_t[m.ph]));
    check("model_side", 32'(side_Lights), 32'(side_t[m.ph]));
    check("model_walk", 32'(walk), 32'(WEN && m.ph == 3));
    check("model_time_left", 32'(time_Left), 32'(m.left));
  end

  task automatic check_out(input string nm, input logic [1:0] iv, input logic [2:0] ml, input logic [2:0] sl, input bit wk, input logic [3:0] tl);
    check({nm, "_interval"}, 32'(interval), 32'(iv));
    check({nm, "_main"}, 32'(main_Lights), 32'(ml));
    check({nm, "_side"}, 32'(side_Lights), 32'(sl));
    check({nm, "_walk"}, 32'(walk), 32'(wk));
    check({nm, "_time_left"}, 32'(time_Left), 32'(tl));
  endtask

  task automatic cyc(input bit tk, input bit sn, input bit wr, input bit rp, input bit rs);
    one_Hz_Enable = tk; sensor = sn; walk_Request = wr; sync_Reprogram = rp; reset = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic period(input bit sn, input bit wr);
    for (int i = 0; i < 10; i++) cyc(i == 5, sn, wr && i == 0, 1'b0, 1'b0);
  endtask

  task automatic periods(input int n);
    for (int i = 0; i < n; i++) period(1'b0, 1'b0);
  endtask

  typedef struct { int n; bit sn; bit wr; logic [1:0] iv; logic [2:0] ml; logic [2:0] sl; bit wk; logic [3:0] tl; } vec_t;
  vec_t tbl [$];

  function automatic void add(int n, bit sn, bit wr, logic [1:0] iv, logic [2:0] ml, logic [2:0] sl, bit wk, logic [3:0] tl);
    tbl.push_back('{n, sn, wr, iv, ml, sl, wk, tl});
  endfunction

  initial begin
    prog = '{4'd6, 4'd3, 4'd2, 4'd0};
    add(1, 0, 0, 2'd0, 3'b001, 3'b100, 0, 4'd5);
    add(5, 0, 0, 2'd1, 3'b001, 3'b100, 0, 4'd3);
    add(3, 0, 0, 2'd2, 3'b010, 3'b100, 0, 4'd2);
    add(2, 0, 0, 2'd0, 3'b100, 3'b001, 0, 4'd6);
    add(6, 0, 0, 2'd2, 3'b100, 3'b010, 0, 4'd2);
    add(2, 0, 0, 2'd0, 3'b001, 3'b100, 0, 4'd6);
    add(1, 1, 0, 2'd0, 3'b001, 3'b100, 0, 4'd5);
    add(5, 0, 0, 2'd2, 3'b010, 3'b100, 0, 4'd2);
    add(2, 0, 0, 2'd0, 3'b100, 3'b001, 0, 4'd6);
    add(5, 0, 0, 2'd0, 3'b100, 3'b001, 0, 4'd1);
    add(1, 1, 0, 2'd1, 3'b100, 3'b001, 0, 4'd3);
    add(3, 0, 0, 2'd2, 3'b100, 3'b010, 0, 4'd2);
    add(2, 0, 0, 2'd0, 3'b001, 3'b100, 0, 4'd6);
    add(6, 0, 0, 2'd1, 3'b001, 3'b100, 0, 4'd3);
    add(3, 0, 0, 2'd2, 3'b010, 3'b100, 0, 4'd2);
    add(2, 0, 0, 2'd0, 3'b100, 3'b001, 0, 4'd6);
    add(1, 0, 1, 2'd0, 3'b100, 3'b001, 0, 4'd5);
    add(5, 0, 0, 2'd2, 3'b100, 3'b010, 0, 4'd2);
    add(2, 0, 0, 2'd0, 3'b001, 3'b100, 0, 4'd6);
    add(6, 0, 0, 2'd1, 3'b001, 3'b100, 0, 4'd3);
    add(3, 0, 0, 2'd2, 3'b010, 3'b100, 0, 4'd2);
    if (WEN) begin
      add(2, 0, 0, 2'd1, 3'b100, 3'b100, 1, 4'd3);
      add(3, 0, 0, 2'd0, 3'b100, 3'b001, 0, 4'd6);
    end else begin
      add(2, 0, 0, 2'd0, 3'b100, 3'b001, 0, 4'd6);
      add(3, 0, 0, 2'd0, 3'b100, 3'b001, 0, 4'd3);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    chk_en = 1'b1;
    check_out("reset", 2'd0, 3'b001, 3'b100, 1'b0, 4'd0);
    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].n; k++) period(tbl[i].sn, tbl[i].wr && k == 0);
      check_out($sformatf("vec%0d", i), tbl[i].iv, tbl[i].ml, tbl[i].sl, tbl[i].wk, tbl[i].tl);
    end
    prog[2] = 4'd0;
    cyc(0, 0, 0, 0, 1);
    periods(9);
    check_out("zero_my", 2'd2, 3'b010, 3'b100, 1'b0, 4'd1);
    periods(1);
    check_out("zero_sg", 2'd0, 3'b100, 3'b001, 1'b0, 4'd6);
    periods(6);
    check_out("zero_sy", 2'd2, 3'b100, 3'b010, 1'b0, 4'd1);
    periods(1);
    check_out("zero_mg", 2'd0, 3'b001, 3'b100, 1'b0, 4'd6);
    prog[2] = 4'd2;
    cyc(0, 0, 0, 0, 1);
    periods(13);
    check_out("rp_pre", 2'd0, 3'b100, 3'b001, 1'b0, 4'd4);
    cyc(1, 0, 0, 1, 0);
    check_out("rp_edge", 2'd0, 3'b001, 3'b100, 1'b0, 4'd0);
    cyc(0, 0, 0, 0, 0);
    check_out("rp_load", 2'd0, 3'b001, 3'b100, 1'b0, 4'd6);
    cyc(0, 0, 0, 0, 1);
    periods(16);
    period(1'b1, 1'b0);
    check_out("rst_sgext", 2'd1, 3'b100, 3'b001, 1'b0, 4'd3);
    periods(1);
    cyc(1, 0, 0, 0, 1);
    check_out("rst_edge", 2'd0, 3'b001, 3'b100, 1'b0, 4'd0);
    cyc(0, 0, 0, 0, 0);
    check_out("rst_load", 2'd0, 3'b001, 3'b100, 1'b0, 4'd6);
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) prog[$urandom_range(0, 2)] = 4'($urandom_range(0, 15));
      cyc($urandom_range(0, 3) == 0, 1'($urandom), $urandom_range(0, 30) == 0,
          $urandom_range(0, 200) == 0, $urandom_range(0, 600) == 0);
    end
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Consumer side of the time-parameter interface: the light sequencer that selects an interval code, reads the programmed duration back, and counts it down in whole seconds. Drives main-street, side-street and pedestrian lamps from a single clock domain. Sits between the time-parameter register block, which answers `interval` with `param_Value`, and the lamp drivers and 1 Hz divider.

## Interface
- `MAX_T`, default 15: largest duration the counter accepts; must fit 4 bits.
- `clk`  in  1  system clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `one_Hz_Enable`  in  1  single-cycle tick, once per second.
- `sensor`  in  1  side-street vehicle present (synchronised upstream).
- `walk_Request`  in  1  pedestrian button, level or pulse.
- `sync_Reprogram`  in  1  one-cycle pulse; parameters were rewritten, restart sequence.
- `param_Value`  in  4  duration in seconds for the code on `interval`; valid in the same cycle.
- `interval`  out  2  00 = base, 01 = extended, 10 = yellow; 11 is never driven.
- `main_Lights`  out  3  {R,Y,G}, one-hot.
- `side_Lights`  out  3  {R,Y,G}, one-hot.
- `walk`  out  1  pedestrian walk lamp.
- `time_Left`  out  4  seconds remaining in the current state, for display.

## Operation
- States, with lamps and interval code:
  - MG: main G, side R, code 00.
  - MG_EXT: main G, side R, code 01.
  - MY: main Y, side R, code 10.
  - WALK: both R, walk=1, code 01.
  - SG: main R, side G, code 00.
  - SG_EXT: main R, side G, code 01.
  - SY: main R, side Y, code 10.
- Transitions, all taken on timer expiry:
  - MG: to MY if `sensor_Seen`, else MG_EXT.
  - MG_EXT: to MY.
  - MY: to WALK if `walk_Pending`, else SG.
  - WALK: to SG.
  - SG: to SG_EXT if `sensor`=1 at the expiry cycle, else SY.
  - SG_EXT: to SY.
  - SY: to MG.
- `sensor_Seen`:
  - Set by any `sensor`=1 cycle while in MG or MG_EXT.
  - Cleared on every entry to MG.
- `walk_Pending`:
  - Set by `walk_Request`=1 in any state.
  - Cleared on exit from WALK.
  - A request arriving during WALK is kept pending for the next cycle.
- Counter, per state entry:
  - First cycle in the state is the LOAD cycle: `counter <= param_Value`.
  - `param_Value`=0 loads 1; values above `MAX_T` clamp to `MAX_T`.
  - A tick coinciding with the LOAD cycle is ignored.
  - After LOAD, each tick decrements the counter.
  - Expiry is the tick that finds counter==1: the state changes on that edge, and the next state's LOAD cycle follows immediately.
- `time_Left` equals the counter; it shows 0 during the LOAD cycle.

## Timing
- Reset (synchronous, wins over everything) puts outputs at:
  - state = MG in LOAD, `interval`=00;
  - `main_Lights`=001, `side_Lights`=100, `walk`=0, `time_Left`=0;
  - `sensor_Seen`=0, `walk_Pending`=0.
- All outputs are registered from state; `interval` changes on the same edge as the state.
- `param_Value` is sampled only in the LOAD cycle. Parameter changes mid-state have no effect until the next entry.
- State duration is N ticks after LOAD, i.e. N to N+1 seconds of wall time depending on tick phase.
- `sync_Reprogram`:
  - Acts on the next edge: returns to MG/LOAD and clears `sensor_Seen`.
  - Keeps `walk_Pending`.
  - Lamps pass through no intermediate yellow.
- Priority, highest first: `reset`, `sync_Reprogram`, expiry, tick decrement.
- Tick and `sync_Reprogram` in the same cycle: the tick is dropped.
- Illegal state encoding: recover to MG/LOAD on the next edge.

## Configuration
- `TRAFFIC_WALK_EN`:
  - Defined: WALK state, `walk_Pending` and the `walk` output behave as above.
  - Undefined: `walk_Request` is ignored, `walk` is tied 0, WALK is never entered, and MY always goes to SG.
  - The port list is identical in both builds.

## Test plan
Bench parameter model returns base=6, ext=3, yellow=2; tick every 10 clk.
- Reset, no sensor, no walk -> sequence MG(6 ticks), MG_EXT(3), MY(2), SG(6), SY(2), MG; `interval` follows 00,01,10,00,10,00.
- `sensor` pulsed during MG, held high at SG expiry -> MG goes to MY after 6 ticks; SG goes to SG_EXT(3) then SY.
- `walk_Request` one-cycle pulse in SG (TRAFFIC_WALK_EN defined) -> next MY is followed by WALK with `walk`=1 and both lamps R for 3 ticks, then SG. Undefined build: `walk` stays 0 throughout.
- Model returns 0 for yellow -> MY and SY each last exactly 1 tick; `time_Left` shows 1.
- `sync_Reprogram` in SG with `time_Left`=4 -> next edge: MG, `interval`=00, `main_Lights`=001, then reloads 6.
- `reset` asserted mid-SG_EXT coincident with a tick -> next edge shows all reset values; the counter is not decremented.
